// File: rtl/pcs_receive_fsm_if.sv
// Code-group input and GMII receive output bundle for the 1000BASE-X PCS receive FSM.
// master = decode stage / observer side, slave = receive FSM.
interface pcs_receive_fsm_if #(
    parameter int unsigned CNT_W = 8
);
    logic             sync_status;
    logic [7:0]       rx_cg;
    logic             rx_cg_k;
    logic             rx_cg_err;
    logic [7:0]       RXD;
    logic             RX_DV;
    logic             RX_ER;
    logic             receiving;
    logic [CNT_W-1:0] pkt_count;
    logic [CNT_W-1:0] err_count;

    modport master (
        output sync_status, rx_cg, rx_cg_k, rx_cg_err,
        input  RXD, RX_DV, RX_ER, receiving, pkt_count, err_count
    );

    modport slave (
        input  sync_status, rx_cg, rx_cg_k, rx_cg_err,
        output RXD, RX_DV, RX_ER, receiving, pkt_count, err_count
    );
endinterface

// File: rtl/pcs_receive_fsm.sv
// 1000BASE-X PCS receive state machine: decoded code-groups in, registered GMII RXD/RX_DV/RX_ER out,
// with saturating packet and error counters.
module pcs_receive_fsm #(
    parameter int unsigned CNT_W    = 8,
    parameter logic [7:0]  PREAMBLE = 8'h55
) (
    input logic              GTX_CLK,
    input logic              mr_main_reset,
    pcs_receive_fsm_if.slave rx
);
    typedef enum logic [2:0] {
        LINK_FAILED,
        WAIT_FOR_K,
        RX_K,
        IDLE_D,
        SOP,
        RECEIVE,
        EXTEND
    } state_t;

    localparam logic [7:0] CG_K28_5 = 8'hBC;
    localparam logic [7:0] CG_S     = 8'hFB;
    localparam logic [7:0] CG_T     = 8'hFD;
    localparam logic [7:0] CG_R     = 8'hF7;
    localparam logic [7:0] CG_D16_2 = 8'h50;
    localparam logic [7:0] CG_D5_6  = 8'hC5;
    localparam logic [7:0] CG_EXT   = 8'h0F;

    state_t           state_q, state_d;
    logic [7:0]       rxd_q, rxd_d;
    logic             rx_dv_q, rx_dv_d;
    logic             rx_er_q, rx_er_d;
    logic [CNT_W-1:0] pkt_count_q, pkt_count_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic             pkt_inc, err_inc;

    logic is_k285, is_s, is_t, is_r, is_idle_d;

    // Decode ignores rx_cg_err; the state logic tests the error flag first.
    assign is_k285   = rx.rx_cg_k  && (rx.rx_cg == CG_K28_5);
    assign is_s      = rx.rx_cg_k  && (rx.rx_cg == CG_S);
    assign is_t      = rx.rx_cg_k  && (rx.rx_cg == CG_T);
    assign is_r      = rx.rx_cg_k  && (rx.rx_cg == CG_R);
    assign is_idle_d = !rx.rx_cg_k && ((rx.rx_cg == CG_D16_2) || (rx.rx_cg == CG_D5_6));

    always_comb begin
        state_d = state_q;
        rxd_d   = 8'h00;
        rx_dv_d = 1'b0;
        rx_er_d = 1'b0;
        pkt_inc = 1'b0;
        err_inc = 1'b0;

        if (!rx.sync_status) begin
            state_d = LINK_FAILED;
            // Losing sync mid-frame must be flagged so the MAC discards the frame.
            if (state_q == SOP || state_q == RECEIVE) begin
                rx_er_d = 1'b1;
                err_inc = 1'b1;
            end
        end else begin
            case (state_q)
                LINK_FAILED: state_d = WAIT_FOR_K;

                WAIT_FOR_K: begin
                    if (!rx.rx_cg_err && is_k285)
                        state_d = RX_K;
                end

                RX_K: begin
                    if (!rx.rx_cg_err && is_idle_d) begin
                        state_d = IDLE_D;
                    end else begin
                        state_d = WAIT_FOR_K;
                        err_inc = 1'b1;
                    end
                end

                IDLE_D: begin
                    if (rx.rx_cg_err) begin
                        state_d = WAIT_FOR_K;
                        err_inc = 1'b1;
                    end else if (is_k285) begin
                        state_d = RX_K;
                    end else if (is_s) begin
                        state_d = SOP;
                        rxd_d   = PREAMBLE;
                        rx_dv_d = 1'b1;
                    end else begin
                        state_d = WAIT_FOR_K;
                        err_inc = 1'b1;
                    end
                end

                // SOP only marks the preamble cycle; its code-group is data like RECEIVE.
                SOP, RECEIVE: begin
                    if (rx.rx_cg_err) begin
                        state_d = RECEIVE;
                        rxd_d   = rx.rx_cg;
                        rx_dv_d = 1'b1;
                        rx_er_d = 1'b1;
                        err_inc = 1'b1;
                    end else if (!rx.rx_cg_k) begin
                        state_d = RECEIVE;
                        rxd_d   = rx.rx_cg;
                        rx_dv_d = 1'b1;
                    end else if (is_t) begin
                        state_d = EXTEND;
                        pkt_inc = 1'b1;
                    end else if (is_k285) begin
                        state_d = RX_K;
                        rx_er_d = 1'b1;
                        err_inc = 1'b1;
                    end else begin
                        state_d = RECEIVE;
                        rxd_d   = rx.rx_cg;
                        rx_dv_d = 1'b1;
                        rx_er_d = 1'b1;
                        err_inc = 1'b1;
                    end
                end

                EXTEND: begin
                    if (!rx.rx_cg_err && is_r) begin
                        rxd_d   = CG_EXT;
                        rx_er_d = 1'b1;
                    end else if (!rx.rx_cg_err && is_k285) begin
                        state_d = RX_K;
                    end else begin
                        state_d = WAIT_FOR_K;
                        err_inc = 1'b1;
                    end
                end

                default: state_d = LINK_FAILED;
            endcase
        end

        pkt_count_d = (pkt_inc && (pkt_count_q != '1)) ? pkt_count_q + CNT_W'(1) : pkt_count_q;
        err_count_d = (err_inc && (err_count_q != '1)) ? err_count_q + CNT_W'(1) : err_count_q;
    end

    always_ff @(posedge GTX_CLK or posedge mr_main_reset) begin
        if (mr_main_reset) begin
            state_q     <= LINK_FAILED;
            rxd_q       <= 8'h00;
            rx_dv_q     <= 1'b0;
            rx_er_q     <= 1'b0;
            pkt_count_q <= '0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            rxd_q       <= rxd_d;
            rx_dv_q     <= rx_dv_d;
            rx_er_q     <= rx_er_d;
            pkt_count_q <= pkt_count_d;
            err_count_q <= err_count_d;
        end
    end

    assign rx.RXD       = rxd_q;
    assign rx.RX_DV     = rx_dv_q;
    assign rx.RX_ER     = rx_er_q;
    assign rx.receiving = (state_q == SOP) || (state_q == RECEIVE) || (state_q == EXTEND);
    assign rx.pkt_count = pkt_count_q;
    assign rx.err_count = err_count_q;
endmodule

// File: tb/tb_pcs_receive_fsm.sv
// Scoreboard bench for pcs_receive_fsm: directed code-group vectors push expected outputs,
// a negedge monitor pops and compares; a CNT_W=2 copy shares the stimulus for saturation.
module tb_pcs_receive_fsm;
    logic       GTX_CLK = 1'b0;
    logic       mr_main_reset = 1'b1;
    logic       sync = 1'b0;
    logic [7:0] cg_r = 8'h00;
    logic       k_r = 1'b0;
    logic       err_r = 1'b0;

    int checks = 0;
    int failures = 0;
    int e_pkt = 0;
    int e_err = 0;

    typedef struct packed {
        logic [7:0] rxd;
        logic       dv;
        logic       er;
        logic       recv;
        logic [7:0] pkt;
        logic [7:0] err;
    } exp_t;

    exp_t exp_q[$];

    always #5 GTX_CLK = ~GTX_CLK;

    pcs_receive_fsm_if #(.CNT_W(8)) rx_if ();
    pcs_receive_fsm_if #(.CNT_W(2)) rx_if2 ();

    assign rx_if.sync_status  = sync;
    assign rx_if.rx_cg        = cg_r;
    assign rx_if.rx_cg_k      = k_r;
    assign rx_if.rx_cg_err    = err_r;
    assign rx_if2.sync_status = sync;
    assign rx_if2.rx_cg       = cg_r;
    assign rx_if2.rx_cg_k     = k_r;
    assign rx_if2.rx_cg_err   = err_r;

    pcs_receive_fsm #(.CNT_W(8), .PREAMBLE(8'h55)) u_dut (
        .GTX_CLK       (GTX_CLK),
        .mr_main_reset (mr_main_reset),
        .rx            (rx_if)
    );

    pcs_receive_fsm #(.CNT_W(2), .PREAMBLE(8'h55)) u_dut_sat (
        .GTX_CLK       (GTX_CLK),
        .mr_main_reset (mr_main_reset),
        .rx            (rx_if2)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] sat3(input logic [7:0] v);
        return (v > 8'd3) ? 8'd3 : v;
    endfunction

    // Drive one code-group, clock it in, and queue what the outputs must show afterwards.
    task automatic send(input logic s, input logic [7:0] cg, input logic k, input logic e,
                        input logic [7:0] xrxd, input logic xdv, input logic xer, input logic xrecv,
                        input logic ipkt, input logic ierr);
        exp_t x;
        sync = s; cg_r = cg; k_r = k; err_r = e;
        @(posedge GTX_CLK);
        if (ipkt) e_pkt++;
        if (ierr) e_err++;
        x.rxd = xrxd; x.dv = xdv; x.er = xer; x.recv = xrecv;
        x.pkt = 8'(e_pkt); x.err = 8'(e_err);
        exp_q.push_back(x);
        #1;
    endtask

    task automatic quiet(input logic [7:0] cg, input logic k);
        send(1'b1, cg, k, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask
    task automatic ipair();
        quiet(8'hBC, 1'b1);
        quiet(8'h50, 1'b0);
    endtask
    task automatic sop();
        send(1'b1, 8'hFB, 1'b1, 1'b0, 8'h55, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask
    task automatic dat(input logic [7:0] cg);
        send(1'b1, cg, 1'b0, 1'b0, cg, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask
    task automatic term();
        send(1'b1, 8'hFD, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    endtask
    task automatic ext_r();
        send(1'b1, 8'hF7, 1'b1, 1'b0, 8'h0F, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    always @(negedge GTX_CLK) begin : monitor
        exp_t x;
        if (exp_q.size() != 0) begin
            x = exp_q.pop_front();
            chk("rxd",       rx_if.RXD,               x.rxd);
            chk("rx_dv",     8'(rx_if.RX_DV),         8'(x.dv));
            chk("rx_er",     8'(rx_if.RX_ER),         8'(x.er));
            chk("receiving", 8'(rx_if.receiving),     8'(x.recv));
            chk("pkt_count", rx_if.pkt_count,         x.pkt);
            chk("err_count", rx_if.err_count,         x.err);
            chk("pkt_sat",   8'(rx_if2.pkt_count),    sat3(x.pkt));
            chk("err_sat",   8'(rx_if2.err_count),    sat3(x.err));
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rxd"},  rx_if.RXD,              8'h00);
        chk({tag, "_dv"},   8'(rx_if.RX_DV),        8'h00);
        chk({tag, "_er"},   8'(rx_if.RX_ER),        8'h00);
        chk({tag, "_recv"}, 8'(rx_if.receiving),    8'h00);
        chk({tag, "_pkt"},  rx_if.pkt_count,        8'h00);
        chk({tag, "_err"},  rx_if.err_count,        8'h00);
        chk({tag, "_pkt2"}, 8'(rx_if2.pkt_count),   8'h00);
        chk({tag, "_err2"}, 8'(rx_if2.err_count),   8'h00);
    endtask

    initial begin
        #2;
        chk_all_zero("reset");
        #10 mr_main_reset = 1'b0;

        // Acquire: first sync cycle leaves LINK_FAILED, then three /I/.
        quiet(8'h00, 1'b0);
        repeat (3) ipair();

        // Clean packet.
        sop();
        dat(8'hC5); dat(8'h00); dat(8'hC5); dat(8'h07); dat(8'hC5);
        term();
        ext_r();
        quiet(8'hBC, 1'b1);
        quiet(8'h50, 1'b0);

        // Invalid code-group on the third data octet.
        sop();
        dat(8'h11); dat(8'h22);
        send(1'b1, 8'h33, 1'b0, 1'b1, 8'h33, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        dat(8'h44);
        term();
        quiet(8'hBC, 1'b1);
        quiet(8'h50, 1'b0);

        // Early end with K28.5, then D returns to IDLE_D.
        sop();
        dat(8'hAA);
        send(1'b1, 8'hBC, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        quiet(8'h50, 1'b0);

        // Unexpected K inside a frame keeps receiving with RX_ER.
        sop();
        dat(8'h01);
        send(1'b1, 8'hF7, 1'b1, 1'b0, 8'hF7, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        dat(8'h02);
        term();
        ext_r();
        quiet(8'hBC, 1'b1);
        quiet(8'h50, 1'b0);

        // Sync loss mid-packet.
        sop();
        dat(8'hC5);
        send(1'b0, 8'h12, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        send(1'b0, 8'h12, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        quiet(8'h12, 1'b0);
        quiet(8'h50, 1'b0);
        ipair();

        // Bad code-groups in RX_K, IDLE_D and EXTEND.
        quiet(8'hBC, 1'b1);
        send(1'b1, 8'h12, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        ipair();
        send(1'b1, 8'h12, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        ipair();
        sop();
        dat(8'h01);
        term();
        send(1'b1, 8'h50, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        ipair();

        // Asynchronous reset mid-packet.
        sop();
        dat(8'hC5);
        @(negedge GTX_CLK);
        #1 mr_main_reset = 1'b1;
        #1 chk_all_zero("async_reset");
        e_pkt = 0;
        e_err = 0;
        #1 mr_main_reset = 1'b0;

        // After reset, /S/ is ignored until K28.5 / D is seen again.
        quiet(8'hC5, 1'b0);
        quiet(8'hFB, 1'b1);
        ipair();

        // Five clean packets: 8-bit counter reaches 5, 2-bit copy holds 3.
        repeat (5) begin
            sop();
            dat(8'hC5); dat(8'h01);
            term();
            ext_r();
            quiet(8'hBC, 1'b1);
            quiet(8'h50, 1'b0);
        end

        @(negedge GTX_CLK);
        #1;
        chk("sat_pkt_final",  8'(rx_if2.pkt_count), 8'd3);
        chk("full_pkt_final", rx_if.pkt_count,       8'd5);
        chk("queue_drained",  8'(exp_q.size()),      8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pcs_receive_fsm.md
Name: pcs_receive_fsm

Overview:
- Receive-side counterpart of the 1000BASE-X PCS transmit path.
- Consumes decoded code-groups (octet plus K flag plus invalid flag) from the synchronization/8b10b-decode stage.
- Runs a Clause-36-style receive state machine and drives the GMII receive outputs RXD/RX_DV/RX_ER.
- Keeps saturating packet and error counters for the bench and management.

Parameters:
- CNT_W, 8, width of the pkt_count and err_count saturating counters.
- PREAMBLE, 8'h55, octet presented on RXD in the cycle that replaces /S/.

Ports:
- GTX_CLK  input  1  single receive clock; all logic on rising edge.
- mr_main_reset  input  1  reset, asynchronous, active-high.
- sync_status  input  1  1 = code-group synchronization acquired (OK).
- rx_cg  input  8  decoded code-group octet.
- rx_cg_k  input  1  1 = rx_cg is a K (control) code-group.
- rx_cg_err  input  1  1 = code-group invalid (disparity or table miss).
- RXD  output  8  GMII receive data.
- RX_DV  output  1  GMII receive data valid.
- RX_ER  output  1  GMII receive error / carrier-extend indication.
- receiving  output  1  high while in SOP, RECEIVE or EXTEND.
- pkt_count  output  CNT_W  packets ended cleanly with /T/.
- err_count  output  CNT_W  invalid or unexpected code-groups seen.

Behaviour:
- Reset, asynchronous while high:
  - state = LINK_FAILED.
  - RXD = 0, RX_DV = 0, RX_ER = 0, receiving = 0.
  - pkt_count = 0, err_count = 0.
- Latency: all outputs are registered. Inputs sampled at edge n appear on outputs after edge n (one cycle).
- Recognised code-groups:
  - K28.5 = 8'hBC with k=1.
  - /S/ = 8'hFB with k=1.
  - /T/ = 8'hFD with k=1.
  - /R/ = 8'hF7 with k=1.
  - Idle data = 8'h50 (D16.2) or 8'hC5 (D5.6) with k=0.
- Priority order:
  1. sync_status = 0.
  2. rx_cg_err.
  3. Code-group decode.
- States and transitions:
  - LINK_FAILED: outputs idle (RX_DV = 0, RX_ER = 0, RXD = 0). Go to WAIT_FOR_K when sync_status = 1.
  - WAIT_FOR_K: outputs idle. Go to RX_K on K28.5; otherwise stay (no error count).
  - RX_K: go to IDLE_D on idle data. Any other value, or rx_cg_err, goes to WAIT_FOR_K with err_count+1.
  - IDLE_D:
    - K28.5 -> RX_K.
    - /S/ -> SOP.
    - Anything else -> WAIT_FOR_K with err_count+1.
  - SOP: RXD = PREAMBLE, RX_DV = 1, RX_ER = 0. Always go to RECEIVE on the next cycle, evaluating that cycle's code-group as in RECEIVE.
  - RECEIVE:
    - Data with k=0 and no error: RXD = rx_cg, RX_DV = 1, RX_ER = 0; stay.
    - /T/: RX_DV = 0, RX_ER = 0, RXD = 0, pkt_count+1 -> EXTEND.
    - K28.5 (early end): RX_DV = 0, RX_ER = 1, err_count+1 -> RX_K.
    - rx_cg_err or any other K: RXD = rx_cg, RX_DV = 1, RX_ER = 1, err_count+1; stay.
  - EXTEND:
    - /R/: RX_DV = 0, RX_ER = 1, RXD = 8'h0F (carrier extend); stay.
    - K28.5: outputs idle -> RX_K.
    - Anything else: err_count+1 -> WAIT_FOR_K, outputs idle.
- sync_status = 0 in any state other than LINK_FAILED:
  - Next state is LINK_FAILED.
  - If the current state is SOP or RECEIVE: RX_DV = 0, RX_ER = 1 for one cycle, err_count+1.
  - Otherwise: outputs idle.
- Counters saturate at all-ones; there is no wrap.
- receiving = 1 exactly when the registered state is SOP, RECEIVE or EXTEND.
- Reset asserted mid-packet clears outputs immediately (asynchronous). The first packet after release requires a full resync through K28.5 / D / /S/.

Test Plan:
- Reset and acquire: sync_status = 1, then three /I/ as BC,50 pairs -> state RX_K/IDLE_D alternating; RX_DV = 0, RX_ER = 0; err_count = 0.
- Clean packet:
  - Stimulus: /I/x3, FB, C5, 00, C5, 07, C5, FD, F7, BC, 50.
  - RXD sequence: 55, C5, 00, C5, 07, C5 with RX_DV = 1, each one cycle after its input.
  - Then RX_DV = 0 on /T/.
  - RX_ER = 1 with RXD = 0F for /R/.
  - Then idle; pkt_count = 1.
- Invalid mid-packet: rx_cg_err = 1 on the third data octet -> that cycle RX_DV = 1, RX_ER = 1; err_count = 1; reception continues; packet ends normally, pkt_count increments.
- Early end: BC arrives in RECEIVE -> RX_DV = 0, RX_ER = 1 one cycle, err_count+1, pkt_count unchanged; a following 50 returns to IDLE_D.
- Sync loss / reset mid-packet:
  - Drop sync_status after FB, C5 -> next cycle RX_DV = 0, RX_ER = 1, then LINK_FAILED idle.
  - Separately, assert mr_main_reset mid-packet -> all outputs 0 without waiting for a clock edge; counters cleared.
- Saturation: with CNT_W = 2, send 5 clean packets -> pkt_count holds 3.
